// File: rtl/pc_reg_pkg.sv
// Shared constants and types for the program-counter stage.
package pc_reg_pkg;

    localparam int unsigned PC_ADDR_W     = 32;
    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned STALL_W       = 6;
    localparam int unsigned STALL_SELF    = 0;
    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_0000;

    // Source of the next fetch address, in decreasing priority.
    typedef enum logic [2:0] {
        SEL_RESET  = 3'd0,
        SEL_FLUSH  = 3'd1,
        SEL_HOLD   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_PEND   = 3'd4,
        SEL_SEQ    = 3'd5
    } pc_sel_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: picks the next fetch address and drives ROM chip enable.
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int unsigned       ADDR_W   = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   new_pc,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_address_i,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                fetch_adel_o
);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] pc_next;
    logic              pend_valid_next;
    logic [ADDR_W-1:0] pend_target_next;
    pc_sel_e           sel;

    // Only bit 0 of the stall vector concerns this stage.
    logic stall_unused;
    assign stall_unused = ^stall[STALL_W-1:1];

    // Priority select of the next pc and the deferred-branch bookkeeping.
    always_comb begin
        pc_next          = pc;
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
        sel              = SEL_SEQ;

        if (!ce) begin
            sel = SEL_RESET;
        end else if (flush) begin
            sel = SEL_FLUSH;
        end else if (stall[STALL_SELF]) begin
            sel = SEL_HOLD;
        end else if (branch_flag_i) begin
            sel = SEL_BRANCH;
        end else if (pend_valid) begin
            sel = SEL_PEND;
        end

        case (sel)
            SEL_RESET: begin
                pc_next = RESET_PC;
            end
            SEL_FLUSH: begin
                pc_next         = new_pc;
                pend_valid_next = 1'b0;
            end
            SEL_HOLD: begin
                // A branch seen while frozen is remembered; a newer one wins.
                if (branch_flag_i) begin
                    pend_valid_next  = 1'b1;
                    pend_target_next = branch_target_address_i;
                end
            end
            SEL_BRANCH: begin
                pc_next         = branch_target_address_i;
                pend_valid_next = 1'b0;
            end
            SEL_PEND: begin
                pc_next         = pend_target;
                pend_valid_next = 1'b0;
            end
            default: begin
                pc_next = pc + ADDR_W'(PC_STEP);
            end
        endcase
    end

    // State register with synchronous reset; ce rises one edge after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce          <= 1'b0;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            ce          <= 1'b1;
            pc          <= pc_next;
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
        end
    end

    // Misaligned fetch flag, derived directly from the registered pc.
    assign fetch_adel_o = ce & (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_reg.sv
// Scoreboard bench for pc_reg: driver queues expectations, negedge monitor checks.
module tb_pc_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] pc;
    logic        ce;
    logic        fetch_adel_o;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        ce;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    pc_reg #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .pc                      (pc),
        .ce                      (ce),
        .fetch_adel_o            (fetch_adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; expectation describes state after the next edge.
    task automatic cyc(input string name, input logic r, input logic [5:0] st,
                       input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt,
                       input logic [31:0] epc, input logic ece, input logic eadel);
        exp_t e;
        rst                     = r;
        stall                   = st;
        flush                   = fl;
        new_pc                  = npc;
        branch_flag_i           = br;
        branch_target_address_i = tgt;
        @(posedge clk);
        e.name = name;
        e.pc   = epc;
        e.ce   = ece;
        e.adel = eadel;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input string name, input logic [31:0] epc, input logic eadel);
        cyc(name, 1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, epc, 1'b1, eadel);
    endtask

    // Monitor: each cycle the DUT presents pc/ce/flag, compare with the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (pc !== e.pc || ce !== e.ce || fetch_adel_o !== e.adel) begin
                errors++;
                $display("FAIL %s: got pc=%h ce=%b adel=%b, expected pc=%h ce=%b adel=%b",
                         e.name, pc, ce, fetch_adel_o, e.pc, e.ce, e.adel);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        // Reset then release.
        for (int i = 0; i < 3; i++)
            cyc("reset", 1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle("release", 32'h0, 1'b0);
        idle("seq4",  32'h4, 1'b0);
        idle("seq8",  32'h8, 1'b0);
        idle("seq12", 32'hC, 1'b0);
        idle("seq16", 32'h10, 1'b0);

        // Branch from ID.
        cyc("branch", 1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h100, 32'h100, 1'b1, 1'b0);
        idle("branch_seq", 32'h104, 1'b0);

        // Branch during stall is deferred until the stall clears.
        cyc("stall_br",   1'b0, 6'b000011, 1'b0, 32'h0, 1'b1, 32'h200, 32'h104, 1'b1, 1'b0);
        cyc("stall_hold", 1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0,   32'h104, 1'b1, 1'b0);
        idle("pend_redirect", 32'h200, 1'b0);
        idle("pend_cleared",  32'h204, 1'b0);

        // Newer branch under stall overwrites the pending target.
        cyc("stall_br_a", 1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h300, 32'h204, 1'b1, 1'b0);
        cyc("stall_br_b", 1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h340, 32'h204, 1'b1, 1'b0);
        idle("pend_newest", 32'h340, 1'b0);
        idle("pend_newest_seq", 32'h344, 1'b0);

        // Live branch supersedes a stale pending one.
        cyc("stale_set",  1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h400, 32'h344, 1'b1, 1'b0);
        cyc("live_br",    1'b0, 6'b000000, 1'b0, 32'h0, 1'b1, 32'h500, 32'h500, 1'b1, 1'b0);
        idle("stale_dropped", 32'h504, 1'b0);

        // Upper stall bits do not freeze this stage.
        cyc("upper_stall", 1'b0, 6'b111110, 1'b0, 32'h0, 1'b0, 32'h0, 32'h508, 1'b1, 1'b0);

        // Flush beats stall, branch and pending.
        cyc("pend_set",  1'b0, 6'b000001, 1'b0, 32'h0,   1'b1, 32'h300, 32'h508, 1'b1, 1'b0);
        cyc("flush_pri", 1'b0, 6'b000001, 1'b1, 32'h180, 1'b1, 32'h300, 32'h180, 1'b1, 1'b0);
        idle("flush_seq", 32'h184, 1'b0);

        // Misaligned fetch and address wrap.
        cyc("misalign", 1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h102, 32'h102, 1'b1, 1'b1);
        idle("misalign_seq", 32'h106, 1'b1);
        cyc("flush_top", 1'b0, 6'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0);
        idle("wrap",     32'h0, 1'b0);
        idle("wrap_seq", 32'h4, 1'b0);

        // Reset in the middle of a stall with a pending branch.
        cyc("mid_pend",  1'b0, 6'b000001, 1'b0, 32'h0, 1'b1, 32'h700, 32'h4, 1'b1, 1'b0);
        cyc("mid_reset", 1'b1, 6'b000001, 1'b1, 32'h900, 1'b1, 32'h800, 32'h0, 1'b0, 1'b0);
        idle("mid_release", 32'h0, 1'b0);
        idle("mid_seq4", 32'h4, 1'b0);
        idle("mid_seq8", 32'h8, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
